// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan scheduler with double-buffered load and per-slot blanking.
// Optional SEG_LZ_BLANK_EN suppresses leading zeros on digits 0..2.
module seg_scan_ctrl #(
  parameter int DIV_W     = 16,
  parameter int TICK_DIV  = 50000,
  parameter int BLANK_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] load_data,
  input  logic        load_valid,
  output logic        load_ready,
  output logic [3:0]  digit_nib,
  output logic [3:0]  digit_sel,
  output logic        blank,
  output logic        frame_done,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  localparam state_t FIRST = (BLANK_CYC == 0) ? SHOW : BLANK;
  localparam logic [DIV_W-1:0] PRE_TOP = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] PRE_BL = DIV_W'(BLANK_CYC - 1);
  localparam logic [DIV_W-1:0] PRE_ONE = DIV_W'(1);
  state_t state_q, state_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0] slot_q, slot_d;
  logic [15:0] shadow_q, shadow_d, pending_q, pending_d;
  logic pend_full_q, pend_full_d;
  logic [3:0] sel_q, sel_d, nib_q, nib_d;
  logic blank_q, blank_d, fd_q, fd_d;
  logic acc, wrap, frame, lz, show;
  always_comb begin
    state_d = state_q;
    pre_d = pre_q;
    slot_d = slot_q;
    shadow_d = shadow_q;
    pending_d = pending_q;
    pend_full_d = pend_full_q;
    acc = load_valid && !pend_full_q;
    wrap = pre_q == PRE_TOP;
    frame = state_q != IDLE && en && wrap && slot_q == 2'd3;
    fd_d = frame;
    if (state_q == IDLE) begin
      if (en) begin
        state_d = FIRST;
        pre_d = '0;
        slot_d = '0;
      end
    end else if (!en) begin
      state_d = IDLE;
      pre_d = '0;
      slot_d = '0;
    end else if (wrap) begin
      state_d = FIRST;
      pre_d = '0;
      slot_d = slot_q + 2'd1;
    end else begin
      pre_d = pre_q + PRE_ONE;
      if (state_q == BLANK && pre_q == PRE_BL) state_d = SHOW;
    end
    // Frame boundary swaps the queued value in; otherwise a load lands in shadow only when idle or at the boundary.
    if (frame && pend_full_q) begin
      shadow_d = pending_q;
      pend_full_d = 1'b0;
    end else if (acc) begin
      if (state_q == IDLE || frame) shadow_d = load_data;
      else begin
        pending_d = load_data;
        pend_full_d = 1'b1;
      end
    end
`ifdef SEG_LZ_BLANK_EN
    lz = slot_d != 2'd3 && (shadow_d >> (4'd12 - {slot_d, 2'b00})) == 16'd0;
`else
    lz = 1'b0;
`endif
    show = state_d == SHOW && !lz;
    sel_d = show ? 4'b0001 << slot_d : 4'b0000;
    nib_d = state_d == IDLE ? 4'h0 : shadow_d[4'd15 - {slot_d, 2'b00} -: 4];
    blank_d = !show;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pre_q <= '0;
      slot_q <= '0;
      shadow_q <= '0;
      pending_q <= '0;
      pend_full_q <= 1'b0;
      sel_q <= '0;
      nib_q <= '0;
      blank_q <= 1'b1;
      fd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pre_q <= pre_d;
      slot_q <= slot_d;
      shadow_q <= shadow_d;
      pending_q <= pending_d;
      pend_full_q <= pend_full_d;
      sel_q <= sel_d;
      nib_q <= nib_d;
      blank_q <= blank_d;
      fd_q <= fd_d;
    end
  end
  assign load_ready = !pend_full_q;
  assign digit_sel = sel_q;
  assign digit_nib = nib_q;
  assign blank = blank_q;
  assign frame_done = fd_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;
  localparam int TD = 8;
  localparam int BC = 2;
  localparam int FRAME = 4 * TD;
  localparam logic [11:0] RST_EXP = 12'b0000_0000_1001;
  logic clk = 1'b0;
  logic rst, en, load_valid, load_ready, blank, frame_done, busy;
  logic [15:0] load_data;
  logic [3:0] digit_nib, digit_sel;
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  bit m_run, m_pf, m_acc;
  int m_k;
  logic [15:0] m_sh, m_pend;

  seg_scan_ctrl #(.DIV_W(16), .TICK_DIV(TD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst), .en(en), .load_data(load_data), .load_valid(load_valid),
    .load_ready(load_ready), .digit_nib(digit_nib), .digit_sel(digit_sel),
    .blank(blank), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] expect_vec(bit fd);
    int slot, ph;
    logic [15:0] hi;
    bit vis;
    if (!m_run) return {8'h00, 1'b1, 1'b0, 1'b0, !m_pf};
    slot = m_k / TD;
    ph = m_k % TD;
    hi = m_sh >> (12 - 4 * slot);
    vis = ph >= BC;
`ifdef SEG_LZ_BLANK_EN
    if (slot < 3 && hi == 16'd0) vis = 0;
`endif
    return {vis ? 4'(1 << slot) : 4'b0000, hi[3:0], !vis, fd, 1'b1, !m_pf};
  endfunction

  // Reference model: a single frame-position counter drives every output.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_run = 0; m_k = 0; m_sh = '0; m_pend = '0; m_pf = 0; m_acc = 0;
      exp_q.delete();
      exp_q.push_back(RST_EXP);
    end else begin
      bit fd;
      fd = 0;
      m_acc = load_valid && !m_pf;
      if (!m_run) begin
        if (m_acc) m_sh = load_data;
        if (en) begin m_run = 1; m_k = 0; end
      end else if (!en) begin
        m_run = 0; m_k = 0;
        if (m_acc) begin m_pend = load_data; m_pf = 1; end
      end else if (m_k == FRAME - 1) begin
        fd = 1;
        m_k = 0;
        if (m_pf) begin m_sh = m_pend; m_pf = 0; end
        else if (m_acc) m_sh = load_data;
      end else begin
        m_k++;
        if (m_acc) begin m_pend = load_data; m_pf = 1; end
      end
      exp_q.push_back(expect_vec(fd));
    end
  end

  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      logic [11:0] e, got;
      e = exp_q.pop_front();
      got = {digit_sel, digit_nib, blank, frame_done, busy, load_ready};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scan t=%0t got sel=%b nib=%h blank=%b fd=%b busy=%b rdy=%b exp sel=%b nib=%h blank=%b fd=%b busy=%b rdy=%b",
          $time, got[11:8], got[7:4], got[3], got[2], got[1], got[0], e[11:8], e[7:4], e[3], e[2], e[1], e[0]);
      end
    end
  end

  task automatic load(input logic [15:0] d);
    bit ok;
    ok = 0;
    load_valid = 1; load_data = d;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      ok = m_acc;
    end
    load_valid = 0;
    checks++;
    if (!ok) begin errors++; $display("FAIL load_timeout data=%h got accepted=0 exp 1", d); end
  endtask

  task automatic wait_k(input int k);
    bit ok;
    ok = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk); #1;
      ok = m_run && m_k == k;
    end
    if (!ok) begin checks++; errors++; $display("FAIL wait_timeout pos=%0d got reached=0 exp 1", k); end
  endtask

  task automatic async_rst();
    #2 rst = 1;
    #1;
    checks++;
    if ({digit_sel, digit_nib, blank, frame_done, busy, load_ready} !== RST_EXP) begin
      errors++;
      $display("FAIL async_rst got %b exp %b", {digit_sel, digit_nib, blank, frame_done, busy, load_ready}, RST_EXP);
    end
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    int fd_cnt;
    logic [15:0] lz_vals [3];
    rst = 1; en = 0; load_valid = 0; load_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    load(16'h0D8C);
    en = 1;
    @(posedge clk);
    fd_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (frame_done) fd_cnt++;
    end
    checks++;
    if (fd_cnt != 3) begin errors++; $display("FAIL frame_count got %0d exp 3", fd_cnt); end
    wait_k(TD + 3);
    load(16'h1234);
    wait_k(FRAME - 1);
    load(16'h1111);
    wait_k(FRAME - 1);
    wait_k(FRAME - 1);
    load(16'hABCD);
    wait_k(2 * TD + 3);
    en = 0;
    repeat (5) @(posedge clk);
    #1 en = 1;
    wait_k(TD + 4);
    async_rst();
    lz_vals = '{16'h000C, 16'h0000, 16'h0D0C};
    foreach (lz_vals[i]) begin
      en = 0;
      @(posedge clk); #1;
      load(lz_vals[i]);
      en = 1;
      repeat (40) @(posedge clk);
      #1;
    end
    for (int c = 0; c < 2500; c++) begin
      @(posedge clk); #1;
      if (load_valid && m_acc) load_valid = 0;
      if (!load_valid && $urandom_range(0, 15) == 0) begin
        load_valid = 1;
        case ($urandom_range(0, 3))
          0: load_data = 16'($urandom);
          1: load_data = 16'($urandom_range(0, 15));
          2: load_data = 16'h0000;
          default: load_data = 16'($urandom_range(0, 4095));
        endcase
      end
      if (!en && $urandom_range(0, 7) == 0) en = 1;
      else if (en && $urandom_range(0, 149) == 0) en = 0;
      if ($urandom_range(0, 499) == 0) async_rst();
    end
    load_valid = 0;
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
